gravity_timer: RTL and testbench
================================

GRAVITY_TIMER -- requirements
Module: gravity_timer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 83_460_000, pixel-clock frequency in Hz.
REQ-002 SHALL have parameter FRAME_HZ, default 60, frame-tick rate in Hz.
REQ-003 SHALL have parameter LEVEL_W, default 5, level input width.
REQ-004 SHALL have parameter SOFT_DIV, default 2, soft-drop gravity period in frames (1..255).
REQ-005 SHALL have port pix_clk input 1, sole clock.
REQ-006 SHALL have port rst input 1, reset: synchronous, active-high, on pix_clk.
REQ-007 SHALL have port enable input 1, 1 = run, 0 = pause.
REQ-008 SHALL have port restart input 1, single-cycle clear of all timing state.
REQ-009 SHALL have port level input LEVEL_W, current game level.
REQ-010 SHALL have port soft_drop input 1, held while the down key is pressed.
REQ-011 SHALL have port tick_frame output 1, one-cycle pulse per frame period.
REQ-012 SHALL have port tick_gravity output 1, one-cycle pulse; piece falls one row.
REQ-013 SHALL have port frame_count output 16, count of frame ticks since reset or restart.

Function
REQ-014 SHALL run a prescaler counting 0..DIV, DIV = CLK_HZ/FRAME_HZ - 1 (integer division), giving exact period DIV+1 cycles.
REQ-015 SHALL register tick_frame high for exactly one cycle, the cycle after the prescaler reaches DIV; the prescaler wraps to 0 in that same cycle.
REQ-016 SHALL keep a gravity counter G (8 bits) that advances only on tick_frame.
REQ-017 SHALL use threshold T = gravity_frames(level) from the package table: 0:48, 1:43, 2:38, 3:33, 4:28, 5:23, 6:18, 7:13, 8:8, 9:6, 10-12:5, 13-15:4, 16-18:3, 19-28:2, 29+:1.
REQ-018 SHALL, on a frame tick where G+1 >= T, pulse tick_gravity in the same cycle as tick_frame and load G to 0; otherwise increment G.
REQ-019 SHALL compare with >=, so a level increase that lowers T below G fires on the next frame tick, never waiting for wrap-around.
REQ-020 SHALL increment frame_count on each tick_frame, wrapping 0xFFFF -> 0.
REQ-021 SHALL implement a two-state FSM: RUN (enable=1) and PAUSE (enable=0); transition takes effect the cycle after enable changes.
REQ-022 SHALL, in PAUSE, freeze the prescaler, G and frame_count, and hold tick_frame and tick_gravity at 0; on return to RUN, resume from the frozen values.
REQ-023 SHALL, on restart=1, clear the prescaler, G and frame_count and suppress both ticks that cycle; restart SHALL take priority over enable and over a coincident terminal count.
REQ-024 SHALL sample level and soft_drop only on the cycle of the frame tick; changes between ticks have no effect.

Reset
REQ-025 SHALL, while rst=1, drive tick_frame=0, tick_gravity=0, frame_count=0, prescaler=0, G=0, FSM=PAUSE; rst takes priority over restart.
REQ-026 SHALL emit the first tick_frame exactly DIV+2 cycles after rst deasserts with enable held at 1 (one cycle FSM entry plus DIV+1).

Configuration
REQ-027 SHALL, with macro GRAVITY_SOFTDROP_EN defined, use effective threshold min(T, SOFT_DIV) while soft_drop=1.
REQ-028 SHALL, with GRAVITY_SOFTDROP_EN undefined, ignore soft_drop and always use T.

Structure
REQ-029 SHALL place the gravity_frames() function, the FSM state enum and the default SOFT_DIV constant in package tetris_timing_pkg.
REQ-030 SHALL implement the prescaler as sub-module frame_divider (ports pix_clk, rst, run, clear, tick).

Verification (CLK_HZ=600, FRAME_HZ=60, DIV=9)
REQ-031 SHALL check: rst released, enable=1, level=8 -> tick_frame every 10 cycles, first at cycle 11; tick_gravity on every 8th tick_frame.
REQ-032 SHALL check: level=0, change to level 29 when G=20 -> tick_gravity on the very next tick_frame, then on every tick_frame.
REQ-033 SHALL check: enable dropped for 37 cycles mid-period -> no ticks during pause; next tick_frame arrives after the remaining prescaler count; frame_count unchanged across pause.
REQ-034 SHALL check: restart asserted on the prescaler-terminal cycle -> no tick that cycle; frame_count=0; next tick_frame after 10 cycles.
REQ-035 SHALL check: GRAVITY_SOFTDROP_EN defined, level=0, soft_drop=1 -> tick_gravity every 2nd tick_frame; macro undefined -> every 48th.
REQ-036 SHALL check: frame_count preloaded by running 65536 ticks -> wraps to 0 with no glitch on tick_gravity.

Source files
------------

// File: rtl/tetris_timing_pkg.sv
// Shared timing definitions for the falling-piece timer: run/pause state
// encoding, default soft-drop period and the level -> gravity-period table.
package tetris_timing_pkg;

    typedef enum logic {
        PAUSE = 1'b0,
        RUN   = 1'b1
    } run_state_e;

    // Soft-drop gravity period in frames when the down key is held.
    localparam int unsigned SOFT_DIV_DEFAULT = 2;

    // Frames per one-row fall for a given level (classic NTSC curve).
    function automatic logic [7:0] gravity_frames(input int unsigned lvl);
        logic [7:0] frames;
        if (lvl >= 29)
            frames = 8'd1;
        else if (lvl >= 19)
            frames = 8'd2;
        else if (lvl >= 16)
            frames = 8'd3;
        else if (lvl >= 13)
            frames = 8'd4;
        else if (lvl >= 10)
            frames = 8'd5;
        else begin
            case (lvl)
                0:       frames = 8'd48;
                1:       frames = 8'd43;
                2:       frames = 8'd38;
                3:       frames = 8'd33;
                4:       frames = 8'd28;
                5:       frames = 8'd23;
                6:       frames = 8'd18;
                7:       frames = 8'd13;
                8:       frames = 8'd8;
                9:       frames = 8'd6;
                default: frames = 8'd48;
            endcase
        end
        return frames;
    endfunction

endpackage

// File: rtl/frame_divider.sv
// Frame prescaler: counts 0..DIV while run is high and flags the terminal
// cycle on tick (combinational strobe, registered by the consumer).
// clear returns the count to 0 and masks the strobe in the same cycle.
module frame_divider #(
    parameter int unsigned DIV = 9
) (
    input  logic pix_clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (DIV > 0) ? $clog2(DIV + 1) : 1;

    logic [CW-1:0] cnt;
    logic          at_term;

    assign at_term = (cnt == CW'(DIV));
    assign tick    = run & at_term & ~clear & ~rst;

    // Prescaler count: frozen when not running, wraps to 0 after DIV.
    always_ff @(posedge pix_clk) begin
        if (rst || clear)
            cnt <= '0;
        else if (run) begin
            if (at_term)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/gravity_timer.sv
// Frame and gravity tick generator for the falling-piece game.
// Optional feature macro: GRAVITY_SOFTDROP_EN (soft_drop caps the gravity
// period at SOFT_DIV frames); without it soft_drop is ignored.
module gravity_timer
    import tetris_timing_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 83_460_000,
    parameter int unsigned FRAME_HZ = 60,
    parameter int unsigned LEVEL_W  = 5,
    parameter int unsigned SOFT_DIV = SOFT_DIV_DEFAULT
) (
    input  logic               pix_clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               restart,
    input  logic [LEVEL_W-1:0] level,
    input  logic               soft_drop,
    output logic               tick_frame,
    output logic               tick_gravity,
    output logic [15:0]        frame_count
);

    localparam int unsigned DIV = CLK_HZ / FRAME_HZ - 1;

    run_state_e state;
    logic       run;
    logic       term;
    logic [7:0] g;
    logic [7:0] t_base;
    logic [7:0] t_eff;
    logic       fire;

    assign run = (state == RUN);

    frame_divider #(
        .DIV (DIV)
    ) u_divider (
        .pix_clk (pix_clk),
        .rst     (rst),
        .run     (run),
        .clear   (restart),
        .tick    (term)
    );

    // Level-dependent threshold, looked up continuously but only consumed on term.
    always_comb begin
        t_base = gravity_frames(32'(level));
    end

`ifdef GRAVITY_SOFTDROP_EN
    // Soft drop shortens the period to SOFT_DIV unless the level is already faster.
    always_comb begin
        t_eff = t_base;
        if (soft_drop && (8'(SOFT_DIV) < t_base))
            t_eff = 8'(SOFT_DIV);
    end
`else
    logic unused_soft_drop;
    assign unused_soft_drop = soft_drop;
    assign t_eff = t_base;
`endif

    // >= rather than == so a lowered threshold fires at once instead of waiting for wrap.
    assign fire = ({1'b0, g} + 9'd1) >= {1'b0, t_eff};

    // Run/pause FSM plus all registered timing state and output pulses.
    always_ff @(posedge pix_clk) begin
        if (rst) begin
            state        <= PAUSE;
            tick_frame   <= 1'b0;
            tick_gravity <= 1'b0;
            g            <= '0;
            frame_count  <= '0;
        end else begin
            state        <= enable ? RUN : PAUSE;
            tick_frame   <= 1'b0;
            tick_gravity <= 1'b0;
            if (restart) begin
                g           <= '0;
                frame_count <= '0;
            end else if (term) begin
                tick_frame  <= 1'b1;
                frame_count <= frame_count + 16'd1;
                if (fire) begin
                    tick_gravity <= 1'b1;
                    g            <= '0;
                end else begin
                    g <= g + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gravity_timer.sv
// Directed bench for gravity_timer at CLK_HZ=600, FRAME_HZ=60 (DIV=9), plus a
// second instance with DIV=0 that ticks every cycle to reach the 16-bit wrap.
module tb_gravity_timer;

    logic        pix_clk = 1'b0;
    always #5 pix_clk = ~pix_clk;

    logic        rst, enable, restart, soft_drop;
    logic [4:0]  level;
    logic        tick_frame, tick_gravity;
    logic [15:0] frame_count;

    logic        rst2, enable2, restart2, soft_drop2;
    logic [4:0]  level2;
    logic        tf2, tg2;
    logic [15:0] fc2;
    logic        wrap_done = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    gravity_timer #(
        .CLK_HZ   (600),
        .FRAME_HZ (60),
        .LEVEL_W  (5),
        .SOFT_DIV (2)
    ) dut (
        .pix_clk      (pix_clk),
        .rst          (rst),
        .enable       (enable),
        .restart      (restart),
        .level        (level),
        .soft_drop    (soft_drop),
        .tick_frame   (tick_frame),
        .tick_gravity (tick_gravity),
        .frame_count  (frame_count)
    );

    gravity_timer #(
        .CLK_HZ   (60),
        .FRAME_HZ (60),
        .LEVEL_W  (5),
        .SOFT_DIV (2)
    ) dut_wrap (
        .pix_clk      (pix_clk),
        .rst          (rst2),
        .enable       (enable2),
        .restart      (restart2),
        .level        (level2),
        .soft_drop    (soft_drop2),
        .tick_frame   (tf2),
        .tick_gravity (tg2),
        .frame_count  (fc2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Counts negedges until tick_frame is seen high; bounded.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge pix_clk);
            n++;
        end while (!tick_frame && n < 200);
        if (!tick_frame)
            check("tick_timeout", {31'd0, tick_frame}, 32'd1);
    endtask

    initial begin
        int n;
        int gcount;
        int pause_bad;
        logic exp_g;

        rst = 1'b1; enable = 1'b1; restart = 1'b0; soft_drop = 1'b0; level = 5'd8;
        repeat (3) @(negedge pix_clk);
        check("reset_tick_frame",   {31'd0, tick_frame},   32'd0);
        check("reset_tick_gravity", {31'd0, tick_gravity}, 32'd0);
        check("reset_frame_count",  {16'd0, frame_count},  32'd0);
        rst = 1'b0;

        // level 8: first tick at cycle 11, then every 10, gravity every 8th
        wait_tick(n);
        check("first_tick_latency", n, 32'd11);
        check("first_tick_grav", {31'd0, tick_gravity}, 32'd0);
        check("first_tick_fc", {16'd0, frame_count}, 32'd1);
        for (int k = 2; k <= 16; k++) begin
            wait_tick(n);
            exp_g = ((k % 8) == 0);
            check($sformatf("l8_period_%0d", k), n, 32'd10);
            check($sformatf("l8_grav_%0d", k), {31'd0, tick_gravity}, {31'd0, exp_g});
            check($sformatf("l8_fc_%0d", k), {16'd0, frame_count}, k);
        end

        // level 0: G climbs to 20 with no gravity
        level = 5'd0;
        gcount = 0;
        for (int k = 17; k <= 36; k++) begin
            wait_tick(n);
            if (tick_gravity) gcount++;
        end
        check("l0_no_grav", gcount, 32'd0);
        check("l0_fc", {16'd0, frame_count}, 32'd36);

        // jump to level 29 with G=20: fires on the very next tick and every tick after
        level = 5'd29;
        for (int k = 37; k <= 39; k++) begin
            wait_tick(n);
            check($sformatf("l29_period_%0d", k), n, 32'd10);
            check($sformatf("l29_grav_%0d", k), {31'd0, tick_gravity}, 32'd1);
        end

        // pause for 37 cycles, 4 cycles into a period
        repeat (4) @(negedge pix_clk);
        enable = 1'b0;
        pause_bad = 0;
        repeat (37) begin
            @(negedge pix_clk);
            if (tick_frame || tick_gravity || frame_count != 16'd39) pause_bad++;
        end
        check("pause_quiet", pause_bad, 32'd0);
        enable = 1'b1;
        wait_tick(n);
        check("resume_latency", n, 32'd6);
        check("resume_fc", {16'd0, frame_count}, 32'd40);
        check("resume_grav", {31'd0, tick_gravity}, 32'd1);

        // restart on the terminal-count cycle
        repeat (9) @(negedge pix_clk);
        restart = 1'b1;
        @(negedge pix_clk);
        restart = 1'b0;
        check("restart_no_tick", {31'd0, tick_frame}, 32'd0);
        check("restart_fc", {16'd0, frame_count}, 32'd0);
        wait_tick(n);
        check("restart_latency", n, 32'd10);
        check("restart_fc_after", {16'd0, frame_count}, 32'd1);

        // soft drop at level 0 from a cleared G
        level = 5'd0;
        soft_drop = 1'b1;
        restart = 1'b1;
        @(negedge pix_clk);
        restart = 1'b0;
        for (int k = 1; k <= 48; k++) begin
            wait_tick(n);
`ifdef GRAVITY_SOFTDROP_EN
            exp_g = ((k % 2) == 0);
`else
            exp_g = (k == 48);
`endif
            check($sformatf("soft_grav_%0d", k), {31'd0, tick_gravity}, {31'd0, exp_g});
        end
        soft_drop = 1'b0;

        for (int i = 0; i < 70000 && !wrap_done; i++)
            @(negedge pix_clk);
        check("wrap_done", {31'd0, wrap_done}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Every-cycle ticks at level 29: frame_count wraps while gravity stays high.
    initial begin
        int glitch;
        rst2 = 1'b1; enable2 = 1'b1; restart2 = 1'b0; soft_drop2 = 1'b0; level2 = 5'd29;
        repeat (3) @(negedge pix_clk);
        rst2 = 1'b0;
        glitch = 0;
        for (int j = 1; j <= 65538; j++) begin
            @(negedge pix_clk);
            if (j == 1)
                check("wrap_idle", {31'd0, tf2}, 32'd0);
            else if (!tf2 || !tg2)
                glitch++;
            if (j == 65536) check("wrap_ffff", {16'd0, fc2}, 32'd65535);
            if (j == 65537) check("wrap_zero", {16'd0, fc2}, 32'd0);
            if (j == 65538) check("wrap_one",  {16'd0, fc2}, 32'd1);
        end
        check("wrap_glitch", glitch, 32'd0);
        wrap_done = 1'b1;
    end

endmodule
